// File: rtl/logo_column_driver_if.sv
// Bundle between the logo column sequencer, its bitmap ROM and the LED shift chain.
// The master side is the sequencer; the slave side is the ROM plus the LED chain.
interface logo_column_driver_if #(
  parameter int unsigned IDX_W = 10,
  parameter int unsigned ROWS  = 38
);
  logic             enable;
  logic [IDX_W-1:0] col_idx;
  logic [ROWS-1:0]  col_data;
  logic             sr_data;
  logic             sr_clk;
  logic             sr_latch;
  logic             frame_start;
  logic             busy;
  logic             overrun;

  modport master (
    input  enable, col_data,
    output col_idx, sr_data, sr_clk, sr_latch, frame_start, busy, overrun
  );

  modport slave (
    output enable, col_data,
    input  col_idx, sr_data, sr_clk, sr_latch, frame_start, busy, overrun
  );
endinterface

// File: rtl/logo_column_driver.sv
// Steps the logo ROM column index, shifts each 38-bit column word MSB first into a
// 595-style LED chain and latches it. Define LOGO_SCROLL_EN to scroll one column per frame.
module logo_column_driver #(
  parameter int unsigned COLS       = 251,
  parameter int unsigned ROWS       = 38,
  parameter int unsigned IDX_W      = 10,
  parameter int unsigned COL_PERIOD = 50000,
  parameter int unsigned SCLK_DIV   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logo_column_driver_if.master bus
);
  localparam int unsigned CNT_W = $clog2(COL_PERIOD + 1);
  localparam int unsigned DIV_W = $clog2(SCLK_DIV + 2);
  localparam int unsigned BIT_W = $clog2(ROWS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COL_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ROWS - 1);
  localparam logic [IDX_W-1:0] COL_LAST = IDX_W'(COLS - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, SHIFT, LATCH, WAIT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [ROWS-1:0]  sh_q, sh_d;
  logic [IDX_W-1:0] col_q, col_d;
  logic [IDX_W-1:0] off_q, off_d;
  logic             sr_data_q, sr_data_d;
  logic             sr_clk_q, sr_clk_d;
  logic             sr_latch_q, sr_latch_d;
  logic             frame_q, frame_d;
  logic             overrun_q, overrun_d;
  logic             period_end;

  assign period_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    col_d      = col_q;
    off_d      = off_q;
    sr_data_d  = sr_data_q;
    sr_clk_d   = sr_clk_q;
    sr_latch_d = sr_latch_q;
    frame_d    = 1'b0;
    overrun_d  = overrun_q;
    // Saturating at the last count lets an overrunning column leave WAIT on its first cycle.
    cnt_d      = period_end ? cnt_q : cnt_q + 1'b1;

    if ((state_q == SETTLE || state_q == SHIFT || state_q == LATCH) && period_end)
      overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.enable) begin
          state_d = SETTLE;
          div_d   = '0;
          frame_d = (col_q == '0);
        end
      end
      SETTLE: begin
        if (div_q == '0) begin
          div_d = DIV_W'(1);
        end else begin
          sh_d      = bus.col_data;
          sr_data_d = bus.col_data[ROWS-1];
          sr_clk_d  = 1'b0;
          div_d     = '0;
          bit_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sr_clk_q) begin
            sr_clk_d = 1'b1;
          end else begin
            sr_clk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              sr_latch_d = 1'b1;
              state_d    = LATCH;
            end else begin
              bit_d     = bit_q + 1'b1;
              sh_d      = sh_q << 1;
              sr_data_d = sh_q[ROWS-2];
            end
          end
        end
      end
      LATCH: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_LAST) begin
          div_d      = '0;
          sr_latch_d = 1'b0;
          state_d    = WAIT;
          col_d      = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
`ifdef LOGO_SCROLL_EN
          if (col_q == COL_LAST)
            off_d = (off_q == COL_LAST) ? '0 : off_q + 1'b1;
`endif
        end
      end
      WAIT: begin
        if (period_end) begin
          cnt_d = '0;
          if (bus.enable) begin
            state_d = SETTLE;
            div_d   = '0;
            frame_d = (col_q == '0);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      col_q      <= '0;
      off_q      <= '0;
      sr_data_q  <= 1'b0;
      sr_clk_q   <= 1'b0;
      sr_latch_q <= 1'b0;
      frame_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      col_q      <= col_d;
      off_q      <= off_d;
      sr_data_q  <= sr_data_d;
      sr_clk_q   <= sr_clk_d;
      sr_latch_q <= sr_latch_d;
      frame_q    <= frame_d;
      overrun_q  <= overrun_d;
    end
  end

`ifdef LOGO_SCROLL_EN
  localparam logic [IDX_W:0] COLS_X = (IDX_W + 1)'(COLS);
  logic [IDX_W:0] idx_sum;
  logic [IDX_W:0] idx_mod;

  assign idx_sum     = {1'b0, col_q} + {1'b0, off_q};
  assign idx_mod     = (idx_sum >= COLS_X) ? idx_sum - COLS_X : idx_sum;
  assign bus.col_idx = idx_mod[IDX_W-1:0];
`else
  logic unused_off;

  assign unused_off  = ^off_q;
  assign bus.col_idx = col_q;
`endif

  assign bus.sr_data     = sr_data_q;
  assign bus.sr_clk      = sr_clk_q;
  assign bus.sr_latch    = sr_latch_q;
  assign bus.frame_start = frame_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.overrun     = overrun_q;
endmodule
